// File: rtl/result_mem_uart_tx_pkg.sv
// Shared types and constants for the result memory UART transmitter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package result_tx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO,
        NEXT,
        FIN
`ifdef RESULT_ROW_DELIM_EN
        ,
        SEND_CR,
        SEND_LF
`endif
    } state_t;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    localparam int         FRAME_BITS     = 10;
    localparam logic [3:0] LAST_FRAME_BIT = 4'(FRAME_BITS - 1);
    localparam logic       IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/result_mem_uart_tx_uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit.
// Latency: start bit on the line 1 cycle after tx_start; frame = 10*CLKS_PER_BIT cycles.
// Backpressure: tx_start is ignored while tx_busy; tx_done pulses in the last stop-bit cycle.
module uart_tx_byte
    import result_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_data,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic              active;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_idx;
    logic [8:0]        shreg;
    logic              bit_end;

    assign bit_end = active && (baud_cnt == BAUD_LAST);
    // Raised during the final stop-bit cycle so the next frame can start with minimal idle time.
    assign tx_done = bit_end && (bit_idx == LAST_FRAME_BIT);
    assign tx_busy = active;

    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
            tx_data  <= IDLE_LEVEL;
        end else if (!active) begin
            if (tx_start) begin
                active   <= 1'b1;
                shreg    <= {1'b1, tx_byte};
                tx_data  <= 1'b0;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end
        end else if (bit_end) begin
            baud_cnt <= '0;
            if (tx_done) begin
                active  <= 1'b0;
                bit_idx <= '0;
                tx_data <= IDLE_LEVEL;
            end else begin
                // Data bits shift out LSB first; the filled-in 1 becomes the stop bit.
                bit_idx <= bit_idx + 4'd1;
                tx_data <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/result_mem_uart_tx.sv
// Result matrix store that streams all words row-major, high byte first, over 8N1 UART (RESULT_ROW_DELIM_EN adds CR LF per row).
// Latency: busy 1 cycle after a read_R_mat rising edge; first start bit 3 cycles after the edge.
// Backpressure: writes and start edges are ignored while busy; done pulses once per transfer.
module result_mem_uart_tx
    import result_tx_pkg::*;
#(
    parameter int ROWS         = 2,
    parameter int COLS         = 2,
    parameter int ADDR_W       = 6,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_R,
    input  logic [ADDR_W-1:0] write_address_R,
    input  logic [15:0]       write_value_R,
    input  logic              read_R_mat,
    output logic              tx_data,
    output logic              busy,
    output logic              done
);

    localparam int                NWORDS   = ROWS * COLS;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NWORDS - 1);

    state_t            state, state_nxt;
    logic [15:0]       mem [0:(1<<ADDR_W)-1];
    logic [15:0]       word_q;
    logic [ADDR_W-1:0] idx;
    logic              read_prev;
    logic              start_req;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_busy;
    logic              tx_done;
`ifdef RESULT_ROW_DELIM_EN
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);
    logic [ADDR_W-1:0] col;
`endif

    assign start_req = read_R_mat && !read_prev && (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    // Storage is deliberately not reset; a write coinciding with a start edge lands before LOAD reads it.
    always_ff @(posedge clk) begin
        if (write_R && (state == IDLE) && (write_address_R <= LAST_IDX))
            mem[write_address_R] <= write_value_R;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            read_prev <= 1'b0;
            word_q    <= '0;
`ifdef RESULT_ROW_DELIM_EN
            col       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            read_prev <= read_R_mat;
            if (state == LOAD)
                word_q <= mem[idx];
            if (state == NEXT && idx != LAST_IDX)
                idx <= idx + 1'b1;
            if (state == FIN)
                idx <= '0;
`ifdef RESULT_ROW_DELIM_EN
            if (state == NEXT)
                col <= (col == LAST_COL) ? '0 : col + 1'b1;
            if (state == FIN)
                col <= '0;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        tx_byte   = word_q[15:8];
        case (state)
            IDLE:    if (start_req) state_nxt = LOAD;
            LOAD:    state_nxt = SEND_HI;
            SEND_HI: begin
                tx_start = !tx_busy;
                if (!tx_busy) state_nxt = WAIT_HI;
            end
            WAIT_HI: if (tx_done) state_nxt = SEND_LO;
            SEND_LO: begin
                tx_byte  = word_q[7:0];
                tx_start = !tx_busy;
                if (!tx_busy) state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                tx_byte = word_q[7:0];
`ifdef RESULT_ROW_DELIM_EN
                if (tx_done) state_nxt = (col == LAST_COL) ? SEND_CR : NEXT;
`else
                if (tx_done) state_nxt = NEXT;
`endif
            end
`ifdef RESULT_ROW_DELIM_EN
            // Delimiter states issue their byte once idle, then hold until that frame completes.
            SEND_CR: begin
                tx_byte  = CR;
                tx_start = !tx_busy;
                if (tx_done) state_nxt = SEND_LF;
            end
            SEND_LF: begin
                tx_byte  = LF;
                tx_start = !tx_busy;
                if (tx_done) state_nxt = NEXT;
            end
`endif
            NEXT:    state_nxt = (idx == LAST_IDX) ? FIN : LOAD;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_byte (tx_byte),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

endmodule

// File: tb/tb_result_mem_uart_tx.sv
// Scoreboard bench: a UART line decoder checks every frame against bytes predicted from a model matrix.
// Stimulus mixes fixed vectors, held requests, ignored writes, mid-frame reset and random contents.
module tb_result_mem_uart_tx;

    localparam int ROWS   = 2;
    localparam int COLS   = 2;
    localparam int ADDR_W = 6;
    localparam int CPB    = 4;
    localparam int NW     = ROWS * COLS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              write_R = 1'b0;
    logic [ADDR_W-1:0] write_address_R = '0;
    logic [15:0]       write_value_R = '0;
    logic              read_R_mat = 1'b0;
    logic              tx_data;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    result_mem_uart_tx #(
        .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .write_R        (write_R),
        .write_address_R(write_address_R),
        .write_value_R  (write_value_R),
        .read_R_mat     (read_R_mat),
        .tx_data        (tx_data),
        .busy           (busy),
        .done           (done)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          done_cnt = 0;
    int          frames_started = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] model_mem [NW];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected byte stream derived from the model matrix contents.
    task automatic push_expected();
        for (int w = 0; w < NW; w++) begin
            exp_q.push_back(model_mem[w][15:8]);
            exp_q.push_back(model_mem[w][7:0]);
`ifdef RESULT_ROW_DELIM_EN
            if (w % COLS == COLS - 1) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
`endif
        end
    endtask

    task automatic write_word(input int addr, input logic [15:0] val);
        write_R         = 1'b1;
        write_address_R = ADDR_W'(addr);
        write_value_R   = val;
        if (addr < NW) model_mem[addr] = val;
        tick();
        write_R = 1'b0;
    endtask

    task automatic load_vectors();
        write_word(0, 16'h1234);
        write_word(1, 16'h00FF);
        write_word(2, 16'hABCD);
        write_word(3, 16'h8001);
    endtask

    // Issue one request and wait (bounded) for done; optional same-cycle write and mid-transfer writes.
    task automatic run_xfer(input bit hold, input bit sim_wr, input int sim_addr,
                            input logic [15:0] sim_val, input bit mid_writes);
        int d0;
        int busy_low;
        bit seen;
        d0 = done_cnt;
        read_R_mat = 1'b1;
        if (sim_wr) begin
            write_R         = 1'b1;
            write_address_R = ADDR_W'(sim_addr);
            write_value_R   = sim_val;
            if (sim_addr < NW) model_mem[sim_addr] = sim_val;
        end
        push_expected();
        tick();
        write_R = 1'b0;
        if (!hold) read_R_mat = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        busy_low = 0;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (mid_writes) begin
                write_R = (i >= 50 && i < 53);
                if (i == 50) begin write_address_R = 6'd0; write_value_R = 16'hFFFF; end
                if (i == 51) begin write_address_R = 6'd7; write_value_R = 16'h5A5A; end
                if (i == 52) begin
                    write_address_R = ADDR_W'($urandom_range(0, NW - 1));
                    write_value_R   = 16'($urandom);
                end
            end
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (!busy) busy_low++;
        end
        write_R = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_held", 32'(busy_low), 32'd0);
        repeat (3) tick();
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin : done_mon
        forever begin
            @(negedge clk);
            if (!rst && done) done_cnt++;
        end
    end

    initial begin : uart_mon
        int         gap;
        bit         gap_armed;
        bit         stable;
        bit         aborted;
        logic [9:0] bits;
        logic [7:0] exp_b;
        gap = 0;
        gap_armed = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap = 0;
                gap_armed = 1'b0;
            end else if (tx_data === 1'b0) begin
                frames_started++;
                if (gap_armed) chk("frame_gap_le3", 32'(gap <= 3), 32'd1);
                stable = 1'b1;
                aborted = 1'b0;
                bits = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) begin
                            @(negedge clk);
                            if (rst) aborted = 1'b1;
                        end
                        if (!aborted) begin
                            if (c == 0) bits[b] = tx_data;
                            else if (tx_data !== bits[b]) stable = 1'b0;
                        end
                    end
                end
                if (aborted) begin
                    gap_armed = 1'b0;
                end else begin
                    chk("frame_shape(stable,start,stop)", {29'd0, stable, bits[0], bits[9]}, 32'b101);
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no frame (t=%0t)", bits[8:1], $time);
                    end else begin
                        exp_b = exp_q.pop_front();
                        chk("tx_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
                    end
                    gap_armed = (exp_q.size() != 0);
                end
                gap = 0;
            end else begin
                gap++;
            end
        end
    end

    initial begin : timeout
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin : main
        int d0;
        int low_cnt;
        int f0;
        bit hit;
        for (int i = 0; i < NW; i++) model_mem[i] = '0;

        repeat (3) tick();
        chk("reset_tx_data", {31'd0, tx_data}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();

        // Zero-initialise contents so every later transfer is fully predictable.
        for (int i = 0; i < NW; i++) write_word(i, 16'h0000);
        load_vectors();
        run_xfer(1'b0, 1'b0, 0, 16'h0, 1'b0);

        // Held request: must not retrigger.
        d0 = done_cnt;
        run_xfer(1'b1, 1'b0, 0, 16'h0, 1'b0);
        low_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_data !== 1'b1 || busy !== 1'b0) low_cnt++;
        end
        chk("held_no_retrigger_line", 32'(low_cnt), 32'd0);
        chk("held_no_retrigger_done", 32'(done_cnt - d0), 32'd1);
        read_R_mat = 1'b0;
        tick();

        // Writes during a transfer (incl. 0xFFFF to addr 0 and addr 7) are ignored.
        run_xfer(1'b0, 1'b0, 0, 16'h0, 1'b1);
        run_xfer(1'b0, 1'b0, 0, 16'h0, 1'b0);

        // Write coinciding with the start edge is included.
        run_xfer(1'b0, 1'b1, 2, 16'hC0DE, 1'b0);

        // Reset during the start bit of the third byte.
        load_vectors();
        d0 = done_cnt;
        f0 = frames_started;
        read_R_mat = 1'b1;
        push_expected();
        tick();
        read_R_mat = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (frames_started >= f0 + 3) hit = 1'b1;
        end
        chk("third_frame_started", 32'(hit), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("midreset_tx_data", {31'd0, tx_data}, 32'd1);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (50) tick();
        chk("midreset_no_done", 32'(done_cnt - d0), 32'd0);
        run_xfer(1'b0, 1'b0, 0, 16'h0, 1'b0);

        // Randomised contents, including out-of-range addresses.
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 6; k++)
                write_word($urandom_range(0, 9), 16'($urandom));
            run_xfer(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 16'($urandom), 1'b0);
            repeat ($urandom_range(1, 20)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
